// File: rtl/ecall_io_unit_if.sv
// rtl/ecall_io_unit_if.sv - ecall request/completion bus between core and I/O unit
interface ecall_io_unit_if;
  logic        Ecall;
  logic [31:0] a0;
  logic [31:0] a7;
  logic        EcallDone;
  logic        EcallWrite;
  logic [31:0] EcallResult;

  modport master (
    output Ecall, a0, a7,
    input  EcallDone, EcallWrite, EcallResult
  );

  modport slave (
    input  Ecall, a0, a7,
    output EcallDone, EcallWrite, EcallResult
  );
endinterface

// File: rtl/ecall_io_unit.sv
// rtl/ecall_io_unit.sv - ecall service unit: print hex, read switches, exit; debounced button, 7-seg scan
module ecall_io_unit #(
  parameter int SW_WIDTH        = 8,
  parameter int NUM_DIGITS      = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SCAN_DIV        = 64
) (
  input  logic                  clk_slow,
  input  logic                  rst,
  ecall_io_unit_if.slave        bus,
  input  logic [SW_WIDTH-1:0]   switches,
  input  logic                  button,
  output logic                  Halted,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] seg_sel
);

  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DGW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(SCAN_DIV - 1);
  localparam logic [DGW-1:0] DG_LAST = DGW'(NUM_DIGITS - 1);

  localparam logic [31:0] CODE_PRINT = 32'd1;
  localparam logic [31:0] CODE_READ  = 32'd5;
  localparam logic [31:0] CODE_EXIT  = 32'd10;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BTN,
    DONE,
    RELEASE,
    HALT
  } state_t;

  state_t              state;
  logic [31:0]         a7_q;
  logic [31:0]         seg_data;
  logic                done;
  logic                write;
  logic [31:0]         result;
  logic                halted;

  logic [1:0]          btn_sync;
  logic                btn_level;
  logic [DBW-1:0]      db_cnt;
  logic                press;
  logic [SW_WIDTH-1:0] sw_meta;
  logic [SW_WIDTH-1:0] sw_sync;

  logic [SCW-1:0]      scan_cnt;
  logic [DGW-1:0]      digit;
  logic [3:0]          nibble;
  logic [6:0]          glyph;

  // The level only flips after DEBOUNCE_CYCLES disagreeing samples in a row;
  // press fires on the same edge that the level rises.
  always_ff @(posedge clk_slow) begin
    if (!rst) begin
      btn_sync  <= 2'b00;
      btn_level <= 1'b0;
      db_cnt    <= '0;
      press     <= 1'b0;
      sw_meta   <= '0;
      sw_sync   <= '0;
    end else begin
      btn_sync <= {btn_sync[0], button};
      sw_meta  <= switches;
      sw_sync  <= sw_meta;
      press    <= 1'b0;
      if (btn_sync[1] != btn_level) begin
        if (db_cnt == DB_LAST) begin
          btn_level <= btn_sync[1];
          db_cnt    <= '0;
          press     <= btn_sync[1];
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Completion outputs are registered one cycle behind the state that requests them.
  always_ff @(posedge clk_slow) begin
    if (!rst) begin
      state    <= IDLE;
      a7_q     <= '0;
      seg_data <= '0;
      done     <= 1'b0;
      write    <= 1'b0;
      result   <= '0;
      halted   <= 1'b0;
    end else begin
      done  <= 1'b0;
      write <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Ecall) begin
            a7_q <= bus.a7;
            case (bus.a7)
              CODE_PRINT: begin
                seg_data <= bus.a0;
                state    <= WAIT_BTN;
              end
              CODE_READ: state <= WAIT_BTN;
              CODE_EXIT: state <= HALT;
              default:   state <= DONE;
            endcase
          end
        end
        WAIT_BTN: begin
          if (press) begin
            if (a7_q == CODE_READ) begin
              result <= 32'(sw_sync);
            end
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          write <= (a7_q == CODE_READ);
          state <= RELEASE;
        end
        RELEASE: begin
          if (!bus.Ecall) begin
            state <= IDLE;
          end
        end
        HALT: begin
          if (!halted) begin
            halted <= 1'b1;
            done   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.EcallDone   = done;
  assign bus.EcallWrite  = write;
  assign bus.EcallResult = result;
  assign Halted          = halted;

  always_ff @(posedge clk_slow) begin
    if (!rst) begin
      scan_cnt <= '0;
      digit    <= '0;
    end else if (scan_cnt == SC_LAST) begin
      scan_cnt <= '0;
      digit    <= (digit == DG_LAST) ? '0 : digit + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_comb begin
    nibble = 4'(seg_data >> {digit, 2'b00});
    glyph  = 7'h3F;
    case (nibble)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      4'hF: glyph = 7'h71;
      default: glyph = 7'h3F;
    endcase
    seg     = {1'b0, glyph};
    seg_sel = NUM_DIGITS'(1) << digit;
  end

endmodule

// File: tb/tb_ecall_io_unit.sv
// tb/tb_ecall_io_unit.sv - directed self-checking bench for ecall_io_unit
module tb_ecall_io_unit;
  logic       clk_slow = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] switches = 8'h00;
  logic       button = 1'b0;
  logic       Halted;
  logic [7:0] seg;
  logic [7:0] seg_sel;

  ecall_io_unit_if bus();

  ecall_io_unit #(
    .SW_WIDTH(8), .NUM_DIGITS(8), .DEBOUNCE_CYCLES(4), .SCAN_DIV(2)
  ) dut (
    .clk_slow(clk_slow), .rst(rst), .bus(bus), .switches(switches),
    .button(button), .Halted(Halted), .seg(seg), .seg_sel(seg_sel)
  );

  always #5 clk_slow = ~clk_slow;

  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  logic        last_write = 1'b0;
  logic [31:0] last_result = 32'h0;

  always @(negedge clk_slow) begin
    if (bus.EcallDone === 1'b1) begin
      done_cnt++;
      last_write  = bus.EcallWrite;
      last_result = bus.EcallResult;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_slow);
      #1;
    end
  endtask

  // Hold the button until EcallDone appears (bounded), then release request and button.
  task automatic service_press(output bit ok);
    ok = 1'b0;
    button = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (bus.EcallDone === 1'b1) ok = 1'b1;
    end
    bus.Ecall = 1'b0;
    tick(2);
    button = 1'b0;
    tick(12);
  endtask

  task automatic wait_digit(input int idx, output bit found);
    logic [7:0] want;
    want = 8'h01 << idx;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (seg_sel === want) found = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.Ecall = 1'b0; bus.a0 = 32'h0; bus.a7 = 32'h0;
    tick(3);
    checks++; if (bus.EcallDone !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.EcallDone); end
    checks++; if (bus.EcallWrite !== 1'b0) begin errors++; $display("FAIL reset_write: got %b expected 0", bus.EcallWrite); end
    checks++; if (bus.EcallResult !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", bus.EcallResult); end
    checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", Halted); end
    checks++; if (seg_sel !== 8'h01) begin errors++; $display("FAIL reset_seg_sel: got %h expected 01", seg_sel); end
    checks++; if (seg !== 8'h3F) begin errors++; $display("FAIL reset_seg: got %h expected 3f", seg); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_print();
    int start;
    bit ok;
    bit found;
    logic [7:0] exp_seg [8];
    exp_seg = '{8'h5E, 8'h39, 8'h7C, 8'h77, 8'h66, 8'h4F, 8'h5B, 8'h06};
    start = done_cnt;
    bus.a7 = 32'd1; bus.a0 = 32'h1234ABCD; bus.Ecall = 1'b1;
    tick(6);
    checks++; if (done_cnt !== start) begin errors++; $display("FAIL print_wait: got %0d done pulses expected 0", done_cnt - start); end
    service_press(ok);
    checks++; if (!ok) begin errors++; $display("FAIL print_done: got no EcallDone expected pulse"); end
    checks++; if (done_cnt !== start + 1) begin errors++; $display("FAIL print_once: got %0d pulses expected 1", done_cnt - start); end
    checks++; if (last_write !== 1'b0) begin errors++; $display("FAIL print_write: got %b expected 0", last_write); end
    for (int i = 0; i < 8; i++) begin
      wait_digit(i, found);
      checks++;
      if (!found || seg !== exp_seg[i]) begin
        errors++; $display("FAIL print_digit%0d: got %h expected %h", i, seg, exp_seg[i]);
      end
    end
  endtask

  task automatic test_read();
    int start;
    bit ok;
    start = done_cnt;
    switches = 8'hA5; bus.a7 = 32'd5; bus.a0 = 32'h0; bus.Ecall = 1'b1;
    tick(4);
    service_press(ok);
    checks++; if (!ok || done_cnt !== start + 1) begin errors++; $display("FAIL read_done: got %0d pulses expected 1", done_cnt - start); end
    checks++; if (last_write !== 1'b1) begin errors++; $display("FAIL read_write: got %b expected 1", last_write); end
    checks++; if (last_result !== 32'h000000A5) begin errors++; $display("FAIL read_result: got %h expected 000000a5", last_result); end
    checks++; if (bus.EcallResult !== 32'h000000A5) begin errors++; $display("FAIL read_hold: got %h expected 000000a5", bus.EcallResult); end
  endtask

  task automatic test_bounce();
    int start;
    int n;
    start = done_cnt;
    switches = 8'h3C; bus.a7 = 32'd5; bus.Ecall = 1'b1;
    tick(4);
    button = 1'b1; tick(); button = 1'b0; tick();
    button = 1'b1; tick(); button = 1'b0; tick();
    button = 1'b1;
    n = 0;
    for (int i = 0; i < 30 && n == 0; i++) begin
      tick();
      if (bus.EcallDone === 1'b1) n = i + 1;
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL bounce_latency: got %0d cycles expected 8", n); end
    bus.Ecall = 1'b0;
    tick(12);
    button = 1'b0;
    tick(12);
    checks++; if (done_cnt !== start + 1) begin errors++; $display("FAIL bounce_once: got %0d pulses expected 1", done_cnt - start); end
    checks++; if (last_result !== 32'h0000003C) begin errors++; $display("FAIL bounce_result: got %h expected 0000003c", last_result); end
  endtask

  task automatic test_back_to_back();
    int start;
    int n;
    start = done_cnt;
    bus.a7 = 32'd7; bus.Ecall = 1'b1;
    n = 0;
    for (int i = 0; i < 10 && n == 0; i++) begin
      tick();
      if (bus.EcallDone === 1'b1) n = i + 1;
    end
    checks++; if (n !== 2) begin errors++; $display("FAIL unknown_latency: got %0d cycles expected 2", n); end
    checks++; if (bus.EcallWrite !== 1'b0) begin errors++; $display("FAIL unknown_write: got %b expected 0", bus.EcallWrite); end
    tick(10);
    checks++; if (done_cnt !== start + 1) begin errors++; $display("FAIL held_once: got %0d pulses expected 1", done_cnt - start); end
    bus.Ecall = 1'b0;
    tick(2);
    bus.Ecall = 1'b1;
    tick(4);
    bus.Ecall = 1'b0;
    tick(2);
    checks++; if (done_cnt !== start + 2) begin errors++; $display("FAIL reissue: got %0d pulses expected 2", done_cnt - start); end
  endtask

  task automatic test_halt();
    int start;
    int n;
    bit ok;
    bit found;
    start = done_cnt;
    bus.a7 = 32'd10; bus.Ecall = 1'b1;
    n = 0;
    for (int i = 0; i < 10 && n == 0; i++) begin
      tick();
      if (bus.EcallDone === 1'b1) n = i + 1;
    end
    checks++; if (n !== 2) begin errors++; $display("FAIL halt_latency: got %0d cycles expected 2", n); end
    checks++; if (Halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b expected 1", Halted); end
    checks++; if (bus.EcallWrite !== 1'b0) begin errors++; $display("FAIL halt_write: got %b expected 0", bus.EcallWrite); end
    tick(10);
    bus.Ecall = 1'b0;
    tick(2);
    bus.a7 = 32'd1; bus.a0 = 32'hDEADBEEF; bus.Ecall = 1'b1;
    tick(3);
    service_press(ok);
    checks++; if (ok || done_cnt !== start + 1) begin errors++; $display("FAIL halt_ignore: got %0d pulses expected 1", done_cnt - start); end
    checks++; if (Halted !== 1'b1) begin errors++; $display("FAIL halt_sticky: got %b expected 1", Halted); end
    wait_digit(0, found);
    checks++; if (!found || seg !== 8'h5E) begin errors++; $display("FAIL halt_digit0: got %h expected 5e", seg); end
    wait_digit(7, found);
    checks++; if (!found || seg !== 8'h06) begin errors++; $display("FAIL halt_digit7: got %h expected 06", seg); end
  endtask

  task automatic test_reset_mid();
    int start;
    logic [7:0] want;
    rst = 1'b0; tick(); rst = 1'b1; tick();
    checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL unhalt: got %b expected 0", Halted); end
    bus.a7 = 32'd1; bus.a0 = 32'h00000055; bus.Ecall = 1'b1;
    tick(5);
    start = done_cnt;
    rst = 1'b0;
    tick();
    checks++; if (bus.EcallResult !== 32'h0) begin errors++; $display("FAIL mid_result: got %h expected 00000000", bus.EcallResult); end
    checks++; if (seg_sel !== 8'h01) begin errors++; $display("FAIL mid_seg_sel: got %h expected 01", seg_sel); end
    checks++; if (seg !== 8'h3F) begin errors++; $display("FAIL mid_seg: got %h expected 3f", seg); end
    checks++; if (bus.EcallDone !== 1'b0 || bus.EcallWrite !== 1'b0) begin errors++; $display("FAIL mid_done: got %b%b expected 00", bus.EcallDone, bus.EcallWrite); end
    bus.Ecall = 1'b0;
    tick();
    rst = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      want = 8'h01 << ((k / 2) % 8);
      checks++;
      if (seg_sel !== want) begin errors++; $display("FAIL scan_k%0d: got %h expected %h", k, seg_sel, want); end
    end
    checks++; if (done_cnt !== start) begin errors++; $display("FAIL mid_dropped: got %0d pulses expected 0", done_cnt - start); end
  endtask

  initial begin
    test_reset();
    test_print();
    test_read();
    test_bounce();
    test_back_to_back();
    test_halt();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
